// File: rtl/gray_binary_seq_if.sv
// Purpose : valid/ready bundle for the sequential Gray-to-binary decoder.
// Signals : gray_valid/gray_ready/gray     - Gray word from the source
//           binary_valid/binary_ready/binary - decoded word to the consumer
// Modports: slave  - decoder side
//           master - source/consumer side
interface gray_binary_seq_if #(
    parameter int unsigned WIDTH = 4
);
    logic             gray_valid;
    logic             gray_ready;
    logic [WIDTH-1:0] gray;
    logic             binary_valid;
    logic             binary_ready;
    logic [WIDTH-1:0] binary;

    modport slave (
        input  gray_valid, gray, binary_ready,
        output gray_ready, binary_valid, binary
    );

    modport master (
        output gray_valid, gray, binary_ready,
        input  gray_ready, binary_valid, binary
    );
endinterface

// File: rtl/gray_binary_seq.sv
// Purpose : sequential Gray-to-binary decoder, one bit per clock, MSB first.
//           A word is accepted in IDLE (or in HOLD on the output transfer
//           edge), resolved over WIDTH CONV cycles, then held in HOLD until
//           the consumer takes it.
// Ports   : clk, rst_n   - clock, asynchronous active-low reset
//           bus (slave)  - gray in / binary out valid-ready handshakes
//           busy         - high whenever the FSM is not in IDLE
//           adj_err      - sticky Gray-adjacency error
// Options : `define GRAY_ADJ_CHECK_EN builds the adjacency checker; when
//           undefined adj_err is tied low.
module gray_binary_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    gray_binary_seq_if.slave   bus,
    output logic               busy,
    output logic               adj_err
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   g_q, g_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q;
    logic               busy_q;
    logic               gray_ready_c;
    logic               accept_c;
    logic [WIDTH-1:0]   shr_c;

    // Already-resolved neighbour bit: bin_q is cleared on capture, so the MSB sees 0.
    assign shr_c = bin_q >> 1;

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        bin_d        = bin_q;
        idx_d        = idx_q;
        gray_ready_c = 1'b0;
        accept_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                gray_ready_c = 1'b1;
            end
            CONV: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        bin_d[i] = shr_c[i] ^ g_q[i];
                    end
                end
                if (idx_q == '0) begin
                    state_d = HOLD;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            HOLD: begin
                gray_ready_c = bus.binary_ready;
                if (bus.binary_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Capture overrides the IDLE/HOLD decisions above
        if (gray_ready_c && bus.gray_valid) begin
            accept_c = 1'b1;
            g_d      = bus.gray;
            bin_d    = '0;
            idx_d    = IDX_W'(WIDTH - 1);
            state_d  = CONV;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            g_q     <= '0;
            bin_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            bin_q   <= bin_d;
            idx_q   <= idx_d;
            valid_q <= (state_d == HOLD);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.gray_ready   = gray_ready_c;
    assign bus.binary_valid = valid_q;
    assign bus.binary       = bin_q;
    assign busy             = busy_q;

`ifdef GRAY_ADJ_CHECK_EN
    logic [WIDTH-1:0] prev_gray_q;
    logic             prev_vld_q;
    logic             adj_err_q;

    // Successive accepted codes must differ in exactly one bit; first word is unchecked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_gray_q <= '0;
            prev_vld_q  <= 1'b0;
            adj_err_q   <= 1'b0;
        end else if (accept_c) begin
            prev_gray_q <= bus.gray;
            prev_vld_q  <= 1'b1;
            if (prev_vld_q && ($countones(bus.gray ^ prev_gray_q) != 1)) begin
                adj_err_q <= 1'b1;
            end
        end
    end

    assign adj_err = adj_err_q;
`else
    assign adj_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_binary_seq.sv
// Purpose : self-checking bench for gray_binary_seq (WIDTH=4 and WIDTH=8).
module tb_gray_binary_seq;

    localparam int unsigned W4 = 4;
    localparam int unsigned W8 = 8;
`ifdef GRAY_ADJ_CHECK_EN
    localparam logic ADJ_EN = 1'b1;
`else
    localparam logic ADJ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gray_binary_seq_if #(.WIDTH(W4)) bus4 ();
    gray_binary_seq_if #(.WIDTH(W8)) bus8 ();
    logic busy4, adj4, busy8, adj8;

    gray_binary_seq #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .busy(busy4), .adj_err(adj4)
    );
    gray_binary_seq #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8), .busy(busy8), .adj_err(adj8)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: inverse of the binary->Gray map, built by enumerating all binaries
    logic [3:0] inv4 [16];
    logic [7:0] inv8 [256];

    typedef struct {
        logic [3:0] gray;
        logic [3:0] bin;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One WIDTH=4 word: accept, measure latency, optional HOLD stall, transfer
    task automatic run4(input logic [3:0] g, input logic [3:0] exp, input int stall,
                        input string name);
        int n;
        int lat;
        @(negedge clk);
        bus4.gray         = g;
        bus4.gray_valid   = 1'b1;
        bus4.binary_ready = (stall == 0);
        n = 0;
        while (!bus4.gray_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus4.gray_ready) begin
            chk({name, " accept timeout"}, 32'(bus4.gray_ready), 32'd1);
            bus4.gray_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus4.gray_valid = 1'b0;
        lat = 0;
        while (!bus4.binary_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(W4));
        chk({name, " binary"}, 32'(bus4.binary), 32'(exp));
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
            chk({name, " stall binary"}, 32'(bus4.binary), 32'(exp));
            chk({name, " stall valid"}, 32'(bus4.binary_valid), 32'd1);
            @(negedge clk);
            bus4.binary_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({name, " valid drop"}, 32'(bus4.binary_valid), 32'd0);
    endtask

    task automatic run8(input logic [7:0] g, input logic [7:0] exp, input string name);
        int n;
        int lat;
        @(negedge clk);
        bus8.gray         = g;
        bus8.gray_valid   = 1'b1;
        bus8.binary_ready = 1'b1;
        n = 0;
        while (!bus8.gray_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus8.gray_ready) begin
            chk({name, " accept timeout"}, 32'(bus8.gray_ready), 32'd1);
            bus8.gray_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus8.gray_valid = 1'b0;
        lat = 0;
        while (!bus8.binary_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(W8));
        chk({name, " binary"}, 32'(bus8.binary), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int n;
        int lat;
        int seen;
        logic [3:0] g4;
        logic [7:0] g8;

        for (int b = 0; b < 16; b++) inv4[4'(b ^ (b >> 1))] = 4'(b);
        for (int b = 0; b < 256; b++) inv8[8'(b ^ (b >> 1))] = 8'(b);

        vecs[0] = '{4'b1101, 4'b1001};
        vecs[1] = '{4'b1011, 4'b1101};
        vecs[2] = '{4'b0110, 4'b0100};
        vecs[3] = '{4'b0000, 4'b0000};
        vecs[4] = '{4'b1000, 4'b1111};
        vecs[5] = '{4'b0001, 4'b0001};

        // Reset with a word offered: nothing captured, ready reads 1
        bus4.gray_valid = 1'b1; bus4.gray = 4'b1101; bus4.binary_ready = 1'b1;
        bus8.gray_valid = 1'b1; bus8.gray = 8'hA5;   bus8.binary_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst binary", 32'(bus4.binary), 32'd0);
        chk("rst valid", 32'(bus4.binary_valid), 32'd0);
        chk("rst busy", 32'(busy4), 32'd0);
        chk("rst adj", 32'(adj4), 32'd0);
        chk("rst ready", 32'(bus4.gray_ready), 32'd1);
        chk("rst8 busy", 32'(busy8), 32'd0);
        chk("rst8 adj", 32'(adj8), 32'd0);
        chk("rst8 valid", 32'(bus8.binary_valid), 32'd0);
        @(negedge clk);
        bus4.gray_valid = 1'b0;
        bus8.gray_valid = 1'b0;
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run4(vecs[i].gray, vecs[i].bin, 0, $sformatf("vec%0d", i));
        end

        // Exhaustive WIDTH=4
        for (int c = 0; c < 16; c++) begin
            run4(4'(c), inv4[c], 0, $sformatf("exh%0d", c));
        end

        // Random WIDTH=4 with random HOLD stalls
        for (int i = 0; i < 30; i++) begin
            g4 = 4'($urandom);
            run4(g4, inv4[g4], int'($urandom_range(0, 3)), $sformatf("rnd4_%0d", i));
        end

        // Random WIDTH=8
        for (int i = 0; i < 30; i++) begin
            g8 = 8'($urandom);
            run8(g8, inv8[g8], $sformatf("rnd8_%0d", i));
        end

        // Backpressure in HOLD with the next word pending, then same-edge transfer+accept
        @(negedge clk);
        bus4.gray = 4'b1101; bus4.gray_valid = 1'b1; bus4.binary_ready = 1'b0;
        n = 0;
        while (!bus4.gray_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        bus4.gray = 4'b1011;
        lat = 0;
        while (!bus4.binary_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("bp latency", 32'(lat), 32'(W4));
        chk("bp binary", 32'(bus4.binary), 32'b1001);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp hold binary %0d", i), 32'(bus4.binary), 32'b1001);
            chk($sformatf("bp hold valid %0d", i), 32'(bus4.binary_valid), 32'd1);
            chk($sformatf("bp hold ready %0d", i), 32'(bus4.gray_ready), 32'd0);
        end
        @(negedge clk);
        bus4.binary_ready = 1'b1;
        #1;
        chk("bp release ready", 32'(bus4.gray_ready), 32'd1);
        @(posedge clk);
        #1;
        bus4.gray_valid = 1'b0;
        chk("bp xfer valid", 32'(bus4.binary_valid), 32'd0);
        chk("bp xfer busy", 32'(busy4), 32'd1);
        lat = 0;
        while (!bus4.binary_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("bp next latency", 32'(lat), 32'(W4));
        chk("bp next binary", 32'(bus4.binary), 32'b1101);
        @(posedge clk);
        #1;
        chk("bp next drop", 32'(bus4.binary_valid), 32'd0);

        // Reset after two CONV cycles aborts the word
        @(negedge clk);
        bus4.gray = 4'b1101; bus4.gray_valid = 1'b1;
        @(posedge clk);
        #1;
        bus4.gray_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy4), 32'd0);
        chk("abort binary", 32'(bus4.binary), 32'd0);
        chk("abort valid", 32'(bus4.binary_valid), 32'd0);
        chk("abort ready", 32'(bus4.gray_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < int'(W4) + 3; i++) begin
            @(posedge clk);
            #1;
            if (bus4.binary_valid) seen++;
        end
        chk("abort no valid", 32'(seen), 32'd0);
        run4(4'b0110, 4'b0100, 0, "after abort");

        // Adjacency sequence from a fresh reset
        do_reset();
        run4(4'b0000, inv4[0], 0, "adj w0");
        chk("adj after w0", 32'(adj4), 32'd0);
        run4(4'b0001, inv4[1], 0, "adj w1");
        chk("adj after w1", 32'(adj4), 32'd0);
        run4(4'b0011, inv4[3], 0, "adj w2");
        chk("adj after w2", 32'(adj4), 32'd0);
        run4(4'b0110, inv4[6], 0, "adj w3");
        chk("adj after w3", 32'(adj4), 32'(ADJ_EN));
        run4(4'b0111, inv4[7], 0, "adj w4");
        chk("adj sticky", 32'(adj4), 32'(ADJ_EN));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("adj reset clear", 32'(adj4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
